// File: rtl/hazard_ctrl_if.sv
// Decode-side hazard bus: instruction fields and redirect/MDU status in, stage controls and forward selects out.
interface hazard_ctrl_if;
  logic       id_valid;
  logic [4:0] id_rs1;
  logic [4:0] id_rs2;
  logic       id_rs1_en;
  logic       id_rs2_en;
  logic [4:0] id_rd;
  logic       id_rd_en;
  logic       id_is_load;
  logic       id_is_mdu;
  logic       ex_redirect;
  logic       mdu_done;
  logic       pc_en;
  logic       ifid_en;
  logic       ifid_flush;
  logic       idex_en;
  logic       idex_bubble;
  logic       exmem_bubble;
  logic       mdu_start;
  logic [1:0] fwd_sel1;
  logic [1:0] fwd_sel2;
  logic       mdu_timeout;

  modport master (
    output id_valid, id_rs1, id_rs2, id_rs1_en, id_rs2_en, id_rd, id_rd_en,
           id_is_load, id_is_mdu, ex_redirect, mdu_done,
    input  pc_en, ifid_en, ifid_flush, idex_en, idex_bubble, exmem_bubble,
           mdu_start, fwd_sel1, fwd_sel2, mdu_timeout
  );

  modport slave (
    input  id_valid, id_rs1, id_rs2, id_rs1_en, id_rs2_en, id_rd, id_rd_en,
           id_is_load, id_is_mdu, ex_redirect, mdu_done,
    output pc_en, ifid_en, ifid_flush, idex_en, idex_bubble, exmem_bubble,
           mdu_start, fwd_sel1, fwd_sel2, mdu_timeout
  );
endinterface

// File: rtl/hazard_ctrl.sv
// RV32I 5-stage pipeline sequencer: EX/MEM rd scoreboard, forwarding, load-use stall, redirect flush, MDU handshake.
// Define HAZARD_CTRL_PERF_EN to add the stall_cycles / flush_count performance counters.
module hazard_ctrl #(
  parameter int MDU_MAX_CYCLES = 40,
  parameter int CNT_W          = 6
) (
  input  logic         clk,
  input  logic         rst,
  hazard_ctrl_if.slave bus
`ifdef HAZARD_CTRL_PERF_EN
  ,
  output logic [31:0]  stall_cycles,
  output logic [31:0]  flush_count
`endif
);

  typedef enum logic {RUN, MDU_WAIT} state_t;

  typedef struct packed {
    logic       vld;
    logic [4:0] rd;
    logic       ld;
  } slot_t;

  state_t           state;
  logic [CNT_W-1:0] cnt;
  logic             timeout;
  slot_t            ex_slot;
  logic             mem_vld;
  logic [4:0]       mem_rd;

  slot_t      id_slot;
  logic       hit1_ex, hit2_ex, hit1_mem, hit2_mem;
  logic       load_use, cnt_last, wait_end, mdu_issue;
  logic       pc_en, ifid_en, ifid_flush, idex_en, idex_bubble, exmem_bubble, mdu_start;
  logic [1:0] fwd1, fwd2;

  // x0 is never marked valid, so it can never produce a match
  assign id_slot  = '{vld: bus.id_rd_en && (bus.id_rd != 5'd0), rd: bus.id_rd, ld: bus.id_is_load};
  assign hit1_ex  = bus.id_valid && bus.id_rs1_en && ex_slot.vld && (ex_slot.rd == bus.id_rs1);
  assign hit2_ex  = bus.id_valid && bus.id_rs2_en && ex_slot.vld && (ex_slot.rd == bus.id_rs2);
  assign hit1_mem = bus.id_valid && bus.id_rs1_en && mem_vld && (mem_rd == bus.id_rs1);
  assign hit2_mem = bus.id_valid && bus.id_rs2_en && mem_vld && (mem_rd == bus.id_rs2);
  assign load_use = ex_slot.ld && (hit1_ex || hit2_ex);
  assign cnt_last = (cnt == CNT_W'(MDU_MAX_CYCLES - 1));
  assign wait_end = bus.mdu_done || cnt_last;
  assign mdu_issue = !bus.ex_redirect && !load_use && bus.id_valid && bus.id_is_mdu;

  always_comb begin
    pc_en        = 1'b1;
    ifid_en      = 1'b1;
    ifid_flush   = 1'b0;
    idex_en      = 1'b1;
    idex_bubble  = 1'b0;
    exmem_bubble = 1'b0;
    mdu_start    = 1'b0;
    fwd1         = 2'b00;
    fwd2         = 2'b00;
    if (rst) begin
      // hold the reset-state controls while reset is asserted, whatever the inputs do
    end else if (state == RUN) begin
      fwd1 = (hit1_ex && !ex_slot.ld) ? 2'b01 : (hit1_mem ? 2'b10 : 2'b00);
      fwd2 = (hit2_ex && !ex_slot.ld) ? 2'b01 : (hit2_mem ? 2'b10 : 2'b00);
      if (bus.ex_redirect) begin
        ifid_flush  = 1'b1;
        idex_bubble = 1'b1;
      end else if (load_use) begin
        pc_en       = 1'b0;
        ifid_en     = 1'b0;
        idex_bubble = 1'b1;
      end else if (mdu_issue) begin
        mdu_start = 1'b1;
      end
    end else begin
      pc_en        = 1'b0;
      ifid_en      = 1'b0;
      idex_en      = 1'b0;
      exmem_bubble = !wait_end;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= RUN;
      cnt     <= '0;
      timeout <= 1'b0;
      ex_slot <= '0;
      mem_vld <= 1'b0;
      mem_rd  <= 5'd0;
    end else begin
      if (state == RUN) begin
        if (mdu_issue) begin
          state <= MDU_WAIT;
          cnt   <= '0;
        end
      end else begin
        cnt <= cnt + 1'b1;
        if (cnt_last && !bus.mdu_done) timeout <= 1'b1;
        if (wait_end) state <= RUN;
      end
      if (idex_en) ex_slot <= (idex_bubble || !bus.id_valid) ? '0 : id_slot;
      mem_vld <= !exmem_bubble && ex_slot.vld;
      mem_rd  <= ex_slot.rd;
    end
  end

`ifdef HAZARD_CTRL_PERF_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stall_cycles <= 32'd0;
      flush_count  <= 32'd0;
    end else begin
      if (!pc_en) stall_cycles <= stall_cycles + 32'd1;
      if (state == RUN && bus.ex_redirect) flush_count <= flush_count + 32'd1;
    end
  end
`endif

  assign bus.pc_en        = pc_en;
  assign bus.ifid_en      = ifid_en;
  assign bus.ifid_flush   = ifid_flush;
  assign bus.idex_en      = idex_en;
  assign bus.idex_bubble  = idex_bubble;
  assign bus.exmem_bubble = exmem_bubble;
  assign bus.mdu_start    = mdu_start;
  assign bus.fwd_sel1     = fwd1;
  assign bus.fwd_sel2     = fwd2;
  assign bus.mdu_timeout  = timeout;

endmodule

// File: tb/tb_hazard_ctrl.sv
// Randomized + directed bench for hazard_ctrl; per-cycle expected controls queued by the driver, checked by a monitor.
module tb_hazard_ctrl;
  localparam int MAXC = 40;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  hazard_ctrl_if bus();

`ifdef HAZARD_CTRL_PERF_EN
  logic [31:0] stall_cycles, flush_count;
`endif

  hazard_ctrl #(.MDU_MAX_CYCLES(MAXC), .CNT_W(6)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
`ifdef HAZARD_CTRL_PERF_EN
    ,
    .stall_cycles(stall_cycles),
    .flush_count(flush_count)
`endif
  );

  typedef struct packed {
    logic       pc_en;
    logic       ifid_en;
    logic       ifid_flush;
    logic       idex_en;
    logic       idex_bubble;
    logic       exmem_bubble;
    logic       mdu_start;
    logic [1:0] f1;
    logic [1:0] f2;
    logic       to;
  } obs_t;

  obs_t expq[$];
  int   checks = 0;
  int   errors = 0;

  // reference state: pipeline contents as plain "who is in EX / MEM" records
  bit          in_mdu = 0;
  int          wait_cycles = 0;
  bit          sticky_to = 0;
  bit          ex_has = 0, ex_is_load = 0, mem_has = 0;
  int          ex_reg = 0, mem_reg = 0;
  logic [31:0] m_stall = 0, m_flush = 0;

  task automatic drive(input logic r, input logic v,
                       input logic [4:0] rs1, input logic e1,
                       input logic [4:0] rs2, input logic e2,
                       input logic [4:0] rd, input logic rde,
                       input logic ld, input logic mdu,
                       input logic redir, input logic done);
    obs_t e;
    bit h1e, h2e, h1m, h2m, lu, go_wait, leave_wait;
    @(posedge clk);
    #1;
    rst = r;
    bus.id_valid = v;   bus.id_rs1 = rs1; bus.id_rs1_en = e1;
    bus.id_rs2 = rs2;   bus.id_rs2_en = e2; bus.id_rd = rd;
    bus.id_rd_en = rde; bus.id_is_load = ld; bus.id_is_mdu = mdu;
    bus.ex_redirect = redir; bus.mdu_done = done;

    e = '0;
    e.pc_en = 1'b1; e.ifid_en = 1'b1; e.idex_en = 1'b1;
    go_wait = 0; leave_wait = 0;
    if (r) begin
      in_mdu = 0; wait_cycles = 0; sticky_to = 0;
      ex_has = 0; ex_is_load = 0; mem_has = 0;
      m_stall = 0; m_flush = 0;
    end else begin
      e.to = sticky_to;
      if (!in_mdu) begin
        h1e = v && e1 && ex_has && (int'(rs1) == ex_reg);
        h2e = v && e2 && ex_has && (int'(rs2) == ex_reg);
        h1m = v && e1 && mem_has && (int'(rs1) == mem_reg);
        h2m = v && e2 && mem_has && (int'(rs2) == mem_reg);
        e.f1 = (h1e && !ex_is_load) ? 2'd1 : (h1m ? 2'd2 : 2'd0);
        e.f2 = (h2e && !ex_is_load) ? 2'd1 : (h2m ? 2'd2 : 2'd0);
        lu = ex_is_load && (h1e || h2e);
        if (redir) begin
          e.ifid_flush = 1; e.idex_bubble = 1; m_flush = m_flush + 1;
        end else if (lu) begin
          e.pc_en = 0; e.ifid_en = 0; e.idex_bubble = 1;
        end else if (v && mdu) begin
          e.mdu_start = 1; go_wait = 1;
        end
      end else begin
        wait_cycles++;
        e.pc_en = 0; e.ifid_en = 0; e.idex_en = 0;
        if (done || wait_cycles == MAXC) begin
          if (!done) sticky_to = 1;
          leave_wait = 1;
        end else begin
          e.exmem_bubble = 1;
        end
      end
      if (!e.pc_en) m_stall = m_stall + 1;
      mem_has = !e.exmem_bubble && ex_has;
      mem_reg = ex_reg;
      if (e.idex_en) begin
        ex_has     = !(e.idex_bubble || !v) && rde && (rd != 5'd0);
        ex_reg     = int'(rd);
        ex_is_load = ld && ex_has;
      end
      if (go_wait) begin in_mdu = 1; wait_cycles = 0; end
      if (leave_wait) in_mdu = 0;
    end
    expq.push_back(e);
  endtask

  task automatic idle(input logic done);
    drive(0, 0, 5'd0, 0, 5'd0, 0, 5'd0, 0, 0, 0, 0, done);
  endtask

  initial begin
    obs_t exp_o, act;
    forever begin
      @(negedge clk);
      if (expq.size() > 0) begin
        exp_o = expq.pop_front();
        act = {bus.pc_en, bus.ifid_en, bus.ifid_flush, bus.idex_en, bus.idex_bubble,
               bus.exmem_bubble, bus.mdu_start, bus.fwd_sel1, bus.fwd_sel2, bus.mdu_timeout};
        checks++;
        if (act !== exp_o) begin
          errors++;
          $display("FAIL ctrl_outputs t=%0t actual=%b required=%b (pc,ifid_en,flush,idex_en,idex_bub,exmem_bub,start,fwd1,fwd2,timeout)",
                   $time, act, exp_o);
        end
      end
    end
  end

  initial begin
    rst = 1'b1;
    bus.id_valid = 0; bus.id_rs1 = 0; bus.id_rs1_en = 0; bus.id_rs2 = 0; bus.id_rs2_en = 0;
    bus.id_rd = 0; bus.id_rd_en = 0; bus.id_is_load = 0; bus.id_is_mdu = 0;
    bus.ex_redirect = 0; bus.mdu_done = 0;

    drive(1, 0, 5'd0, 0, 5'd0, 0, 5'd0, 0, 0, 0, 0, 0);
    drive(1, 1, 5'd3, 1, 5'd3, 1, 5'd3, 1, 1, 1, 1, 1);
    // add x5 ; sub x6,x5,x7 -> EX forward
    drive(0, 1, 5'd1, 1, 5'd2, 1, 5'd5, 1, 0, 0, 0, 0);
    drive(0, 1, 5'd5, 1, 5'd7, 1, 5'd6, 1, 0, 0, 0, 0);
    // add x5 ; independent ; sub -> MEM forward
    drive(0, 1, 5'd1, 1, 5'd2, 1, 5'd5, 1, 0, 0, 0, 0);
    drive(0, 1, 5'd8, 1, 5'd9, 1, 5'd10, 1, 0, 0, 0, 0);
    drive(0, 1, 5'd5, 1, 5'd7, 1, 5'd6, 1, 0, 0, 0, 0);
    // lw x3 ; add x4,x3,x1 held in decode across the stall
    drive(0, 1, 5'd2, 1, 5'd0, 0, 5'd3, 1, 1, 0, 0, 0);
    drive(0, 1, 5'd3, 1, 5'd1, 1, 5'd4, 1, 0, 0, 0, 0);
    drive(0, 1, 5'd3, 1, 5'd1, 1, 5'd4, 1, 0, 0, 0, 0);
    idle(0);
    // lw x0 ; add reading x0 -> no stall
    drive(0, 1, 5'd2, 1, 5'd0, 0, 5'd0, 1, 1, 0, 0, 0);
    drive(0, 1, 5'd0, 1, 5'd1, 1, 5'd4, 1, 0, 0, 0, 0);
    // redirect coinciding with a load-use hazard
    drive(0, 1, 5'd2, 1, 5'd0, 0, 5'd3, 1, 1, 0, 0, 0);
    drive(0, 1, 5'd3, 1, 5'd1, 1, 5'd4, 1, 0, 0, 1, 0);
    idle(0);
    // mul x9, done on the fifth wait cycle; id/redirect noise ignored while waiting
    drive(0, 1, 5'd1, 1, 5'd2, 1, 5'd9, 1, 0, 1, 0, 0);
    repeat (4) drive(0, 1, 5'd9, 1, 5'd9, 1, 5'd9, 1, 1, 1, 1, 0);
    drive(0, 1, 5'd9, 1, 5'd9, 1, 5'd9, 1, 1, 1, 1, 1);
    drive(0, 1, 5'd9, 1, 5'd2, 1, 5'd11, 1, 0, 0, 0, 0);
    idle(1);
    // mul with no done -> timeout, then sticky
    drive(0, 1, 5'd1, 1, 5'd2, 1, 5'd12, 1, 0, 1, 0, 0);
    repeat (45) idle(0);
    // reset in the middle of a wait
    drive(0, 1, 5'd1, 1, 5'd2, 1, 5'd13, 1, 0, 1, 0, 0);
    repeat (3) idle(0);
    drive(1, 1, 5'd13, 1, 5'd13, 1, 5'd1, 1, 1, 1, 1, 0);
    drive(0, 1, 5'd13, 1, 5'd13, 1, 5'd1, 1, 0, 0, 0, 0);
    idle(0);

    repeat (3000) begin
      drive($urandom_range(0, 299) == 0, $urandom_range(0, 9) != 0,
            5'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
            5'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
            5'($urandom_range(0, 3)), $urandom_range(0, 4) != 0,
            $urandom_range(0, 3) == 0, $urandom_range(0, 11) == 0,
            $urandom_range(0, 9) == 0, $urandom_range(0, 4) == 0);
    end

    @(posedge clk);
    #1;
    checks++;
    if (expq.size() != 0) begin
      errors++;
      $display("FAIL queue_drain actual=%0d pending required=0", expq.size());
    end
`ifdef HAZARD_CTRL_PERF_EN
    checks++;
    if (stall_cycles !== m_stall) begin
      errors++;
      $display("FAIL stall_cycles actual=%0d required=%0d", stall_cycles, m_stall);
    end
    checks++;
    if (flush_count !== m_flush) begin
      errors++;
      $display("FAIL flush_count actual=%0d required=%0d", flush_count, m_flush);
    end
`endif
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/hazard_ctrl.md
Name: hazard_ctrl

Overview:
- Pipeline sequencer for the 5-stage RV32I core.
- Keeps a registered scoreboard of the destination registers held in the EX and MEM stages.
- From that scoreboard it produces operand-forward selects for the ALU operand muxes, load-use stalls, branch/jump flushes, and a start/done handshake with the multi-cycle mul/div unit (MDU).
- Sits beside the decode stage and drives every stage enable and bubble in the pipeline.

Parameters:
- MDU_MAX_CYCLES, default 40: longest MDU wait before timeout is declared.
- CNT_W, default 6: width of the MDU wait counter. Must satisfy 2^CNT_W > MDU_MAX_CYCLES.

Ports:
- clk  in  1  core clock, rising edge.
- rst  in  1  reset, asynchronous, active-high.
- id_valid  in  1  the decode stage holds a real instruction.
- id_rs1, id_rs2  in  5 each  source register indices.
- id_rs1_en, id_rs2_en  in  1 each  source actually read.
- id_rd  in  5  destination index.
- id_rd_en  in  1  instruction writes rd.
- id_is_load  in  1  instruction is a load.
- id_is_mdu  in  1  instruction is a mul/div.
- ex_redirect  in  1  branch taken or jal/jalr resolved in EX.
- mdu_done  in  1  MDU result valid, one-cycle pulse.
- pc_en  out  1  PC update enable.
- ifid_en  out  1  IF/ID register enable.
- ifid_flush  out  1  clear IF/ID to NOP.
- idex_en  out  1  ID/EX register enable.
- idex_bubble  out  1  load NOP into ID/EX.
- exmem_bubble  out  1  load NOP into EX/MEM.
- mdu_start  out  1  one-cycle start pulse to the MDU.
- fwd_sel1, fwd_sel2  out  2 each  00 = register file, 01 = EX result, 10 = MEM result, 11 = unused.
- mdu_timeout  out  1  sticky error flag.

Behaviour:
- Reset (asynchronous, any time including during MDU_WAIT):
  - State = RUN; both scoreboard slots invalid; counter = 0; mdu_timeout = 0.
  - Resulting outputs: pc_en = ifid_en = idex_en = 1; all flush/bubble/start = 0; fwd_sel = 00.
- Scoreboard slots:
  - Each slot holds {valid, rd, is_load}.
  - valid is set only when rd_en = 1 and rd != 0, so x0 never matches.
- Scoreboard update on each rising edge:
  - EX slot: if idex_en = 1, it loads the ID fields, or invalid when idex_bubble = 1 or id_valid = 0. If idex_en = 0, it holds.
  - MEM slot: loads the EX slot, or invalid when exmem_bubble = 1.
- Forwarding (combinational; requires rsN_en = 1 and id_valid = 1):
  - rsN matches the EX slot (non-load) -> 01.
  - Otherwise rsN matches the MEM slot -> 10.
  - Otherwise -> 00.
  - EX has priority over MEM.
- Load-use hazard:
  - Condition: the EX slot is a load and its rd matches an enabled rs1 or rs2.
  - Response, one cycle only: pc_en = 0, ifid_en = 0, idex_bubble = 1.
  - The next cycle the load sits in MEM, so forwarding returns 10.
- FSM, state RUN, priorities in order:
  1. ex_redirect: ifid_flush = 1 and idex_bubble = 1, pc_en = 1. This overrides any load-use stall and any MDU issue, and no mdu_start is issued.
  2. Load-use hazard: stall as described above.
  3. id_valid = 1 and id_is_mdu = 1 with no hazard: mdu_start = 1, the instruction advances into EX, counter cleared, next state MDU_WAIT.
- FSM, state MDU_WAIT:
  - Every cycle: pc_en = ifid_en = idex_en = 0, exmem_bubble = 1, counter increments.
  - On mdu_done: exmem_bubble = 0 that cycle so the result enters MEM; next state RUN.
  - If the counter reaches MDU_MAX_CYCLES with no mdu_done: set mdu_timeout, then behave as mdu_done.
  - ex_redirect and id_* inputs are ignored.
- mdu_done arriving while in RUN is ignored.
- mdu_timeout is cleared only by rst.

Optional Feature:
- Macro: HAZARD_CTRL_PERF_EN.
- When defined, adds:
  - Output stall_cycles (32-bit): counts cycles with pc_en = 0.
  - Output flush_count (32-bit): counts ex_redirect events accepted in RUN.
  - Both counters reset to 0 on rst and wrap modulo 2^32.
- When undefined: neither port nor counter exists, and the remaining behaviour is identical.

Test Plan:
- Back-to-back ALU ops, add x5 then sub x6,x5,x7 -> fwd_sel1 = 01 in the sub's decode cycle. With an independent op in between -> fwd_sel1 = 10.
- lw x3 then add x4,x3,x1 -> one cycle with pc_en = 0 and idex_bubble = 1, then fwd_sel1 = 10 and no further stall. Same sequence with rd = x0 -> no stall.
- ex_redirect in the same cycle as a load-use hazard -> ifid_flush = 1, idex_bubble = 1, pc_en = 1, no stall cycle.
- mul issued, mdu_done asserted 5 cycles later -> mdu_start single pulse, pc_en low for 5 cycles, exmem_bubble drops in the done cycle, back to RUN.
- mdu_done never asserted, MDU_MAX_CYCLES = 40 -> mdu_timeout rises after 40 wait cycles and stays high; RUN resumes.
- rst pulsed mid-MDU_WAIT -> all outputs return to reset values immediately and the scoreboard is cleared.
